ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_line_sync.sv | 46 ++++
 rtl/ps2_host_tx.sv | 212 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// PS/2 host transmit shared definitions: FSM states, command bytes, parity helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      START,
      SHIFT,
      STOP,
      ACK,
      RELEASE_WAIT
   } ps2_state_t;

   // Common host-to-device command bytes
   localparam logic [7:0] CMD_SET_LED = 8'hED;
   localparam logic [7:0] CMD_ECHO    = 8'hEE;
   localparam logic [7:0] CMD_RESEND  = 8'hFE;
   localparam logic [7:0] CMD_RESET   = 8'hFF;

   // Number of consecutive identical synchronized samples before the filtered level moves
   localparam int FILTER_LEN = 4;

   // PS/2 frames carry odd parity: the parity bit makes the count of ones odd
   function automatic logic odd_parity(input logic [7:0] d);
      return ~(^d);
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 line conditioner: 2-FF synchronizer, FILTER_LEN-sample stable filter, falling-edge pulse.
// Latency: raw line change to filt/fall is 2 sync + FILTER_LEN samples + 1 register = 7 cycles.
// Backpressure: none; free-running on every clock, fall is a single-cycle pulse.
module ps2_line_sync
   import ps2_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic filt,
   output logic fall
);

   logic                  sync_1;
   logic                  sync_2;
   logic [FILTER_LEN-1:0] hist;
   logic                  filt_next;

   // Filtered level only moves once the whole sample history agrees
   always_comb begin
      filt_next = filt;
      if (hist == '0) begin
         filt_next = 1'b0;
      end else if (hist == '1) begin
         filt_next = 1'b1;
      end
   end

   // Synchronizer, sample history, filtered level and falling-edge pulse; idle lines read high
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
         hist   <= '1;
         filt   <= 1'b1;
         fall   <= 1'b0;
      end else begin
         sync_1 <= raw;
         sync_2 <= sync_1;
         hist   <= {hist[FILTER_LEN-2:0], sync_2};
         filt   <= filt_next;
         fall   <= filt & ~filt_next;
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (inhibit, start, 8 data, odd parity, stop, device ACK).
// Latency: INHIBIT_CYCLES + 11 device clocks + line-release wait; done/err 8 cycles after the deciding raw edge.
// Backpressure: tx_start accepted only in IDLE with no done/err pulse; busy covers the whole frame.
// Optional build macro PS2_TX_RETRY_EN: one automatic resend after the first NACK or timeout.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 12000,  // must be >= 2
   parameter int TIMEOUT_CYCLES = 2000000
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [INH_W-1:0] INH_DATA = INH_W'(INHIBIT_CYCLES - 2);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

   ps2_state_t       state;
   logic [INH_W-1:0] inh_cnt;
   logic [WD_W-1:0]  wd_cnt;
   logic [7:0]       shift_byte;
   logic             parity;
   logic [2:0]       bit_idx;
   logic             clk_filt;
   logic             clk_fall;
   logic             data_filt;
   logic             data_fall;
   logic             timeout;
   logic             nack;
   logic             fail;
`ifdef PS2_TX_RETRY_EN
   logic             retried;
`endif

   ps2_line_sync u_clk_sync (
      .clk  (clk),
      .rst  (rst),
      .raw  (ps2_clk_in),
      .filt (clk_filt),
      .fall (clk_fall)
   );

   ps2_line_sync u_data_sync (
      .clk  (clk),
      .rst  (rst),
      .raw  (ps2_data_in),
      .filt (data_filt),
      .fall (data_fall)
   );

   // A frame fails when the device goes quiet too long or leaves data high on the ACK clock
   always_comb begin
      timeout = (state inside {START, SHIFT, STOP, ACK, RELEASE_WAIT}) && (wd_cnt == WD_LAST);
      nack    = (state == ACK) && clk_fall && data_filt;
      fail    = timeout || nack;
   end

   // Frame sequencer; all line drives and status flags are registered here
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         inh_cnt     <= '0;
         wd_cnt      <= '0;
         shift_byte  <= '0;
         parity      <= 1'b0;
         bit_idx     <= '0;
`ifdef PS2_TX_RETRY_EN
         retried     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (fail) begin
`ifdef PS2_TX_RETRY_EN
            if (!retried) begin
               // Resend the latched byte once, starting again with a fresh inhibit
               retried     <= 1'b1;
               state       <= INHIBIT;
               ps2_clk_oe  <= 1'b1;
               ps2_data_oe <= 1'b0;
               inh_cnt     <= '0;
               wd_cnt      <= '0;
            end else begin
               state       <= IDLE;
               ps2_clk_oe  <= 1'b0;
               ps2_data_oe <= 1'b0;
               busy        <= 1'b0;
               err         <= 1'b1;
               wd_cnt      <= '0;
            end
`else
            state       <= IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b1;
            wd_cnt      <= '0;
`endif
         end else begin
            case (state)
               IDLE: begin
                  // A request landing on the done/err cycle belongs to the old frame and is dropped
                  if (tx_start && !done && !err) begin
                     shift_byte  <= tx_data;
                     parity      <= odd_parity(tx_data);
                     state       <= INHIBIT;
                     ps2_clk_oe  <= 1'b1;
                     ps2_data_oe <= 1'b0;
                     busy        <= 1'b1;
                     inh_cnt     <= '0;
`ifdef PS2_TX_RETRY_EN
                     retried     <= 1'b0;
`endif
                  end
               end
               INHIBIT: begin
                  inh_cnt <= inh_cnt + 1'b1;
                  // Start bit goes on the line in the final inhibit cycle
                  if (inh_cnt == INH_DATA) begin
                     ps2_data_oe <= 1'b1;
                  end
                  if (inh_cnt == INH_LAST) begin
                     state      <= START;
                     ps2_clk_oe <= 1'b0;
                     wd_cnt     <= '0;
                  end
               end
               START: begin
                  if (clk_fall) begin
                     ps2_data_oe <= ~shift_byte[0];
                     bit_idx     <= 3'd1;
                     state       <= SHIFT;
                     wd_cnt      <= '0;
                  end else begin
                     wd_cnt <= wd_cnt + 1'b1;
                  end
               end
               SHIFT: begin
                  if (clk_fall) begin
                     wd_cnt <= '0;
                     // bit_idx wraps to 0 after bit 7 has been driven: next slot is parity
                     if (bit_idx == 3'd0) begin
                        ps2_data_oe <= ~parity;
                        state       <= STOP;
                     end else begin
                        ps2_data_oe <= ~shift_byte[bit_idx];
                        bit_idx     <= bit_idx + 1'b1;
                     end
                  end else begin
                     wd_cnt <= wd_cnt + 1'b1;
                  end
               end
               STOP: begin
                  if (clk_fall) begin
                     ps2_data_oe <= 1'b0;
                     state       <= ACK;
                     wd_cnt      <= '0;
                  end else begin
                     wd_cnt <= wd_cnt + 1'b1;
                  end
               end
               ACK: begin
                  // Data-high case is caught as a NACK above; here the device pulled data low
                  if (clk_fall) begin
                     state  <= RELEASE_WAIT;
                     wd_cnt <= '0;
                  end else if (data_fall) begin
                     // Device pulling data low for its ACK is also proof of life
                     wd_cnt <= '0;
                  end else begin
                     wd_cnt <= wd_cnt + 1'b1;
                  end
               end
               RELEASE_WAIT: begin
                  if (clk_filt && data_filt) begin
                     state  <= IDLE;
                     done   <= 1'b1;
                     busy   <= 1'b0;
                     wd_cnt <= '0;
                  end else begin
                     wd_cnt <= wd_cnt + 1'b1;
                  end
               end
               default: begin
                  state       <= IDLE;
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  busy        <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device model clocking at a 40-cycle period, table of frames plus corner sequences.
// Latency: line edge to DUT reaction is 8 clk (2 sync + 4 stable + edge register + FSM register).
// Backpressure: tx_start re-pulses while busy and on the done cycle must be dropped.
module tb_ps2_host_tx;

   localparam int INH      = 20;
   localparam int TMO      = 300;
   localparam int EDGE_LAT = 8;
`ifdef PS2_TX_RETRY_EN
   localparam int ATTEMPTS = 2;
`else
   localparam int ATTEMPTS = 1;
`endif

   typedef struct {
      logic [7:0] data;
      int         n_edges;
      bit         ack;
      bit         exp_done;
      bit         exp_err;
      logic [7:0] exp_byte;
      bit         exp_par;
      int         exp_gap;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;
   logic       busy;
   logic       done;
   logic       err;
   logic       dev_clk;
   logic       dev_data;
   logic       clk_line;
   logic       data_line;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Monitor state, written only by the monitor block
   int         done_cnt  = 0;
   int         err_cnt   = 0;
   int         both_cnt  = 0;
   int         inh_runs  = 0;
   int         run_len   = 0;
   int         run_dpos  = 0;
   int         last_run  = 0;
   int         last_dpos = 0;
   int         err_cyc   = 0;
   logic       end_busy  = 1'b0;
   logic [1:0] end_oe    = 2'b00;

   assign clk_line  = ~ps2_clk_oe & dev_clk;
   assign data_line = ~ps2_data_oe & dev_data;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .ps2_clk_in  (clk_line),
      .ps2_data_in (data_line),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   // Observe pulses and inhibit windows mid-cycle
   always @(negedge clk) begin
      if (done) begin
         done_cnt = done_cnt + 1;
         end_busy = busy;
         end_oe   = {ps2_clk_oe, ps2_data_oe};
      end
      if (err) begin
         err_cnt  = err_cnt + 1;
         err_cyc  = cyc;
         end_busy = busy;
         end_oe   = {ps2_clk_oe, ps2_data_oe};
      end
      if (done && err) both_cnt = both_cnt + 1;
      if (ps2_clk_oe) begin
         run_len = run_len + 1;
         if (ps2_data_oe && run_dpos == 0) run_dpos = run_len;
      end else if (run_len != 0) begin
         last_run  = run_len;
         last_dpos = run_dpos;
         inh_runs  = inh_runs + 1;
         run_len   = 0;
         run_dpos  = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic pulse(input logic [7:0] d);
      tx_data  = d;
      tx_start = 1'b1;
      tick();
      tx_start = 1'b0;
   endtask

   // Device: wait for an inhibit then the start condition, generate n_edges clocks, sample after each rise
   task automatic device(input int n_edges, input bit ack, output logic [10:0] frame,
                         output int last_fall, output bit ok);
      int w;
      frame     = '1;
      last_fall = 0;
      ok        = 1'b0;
      dev_clk   = 1'b1;
      dev_data  = 1'b1;
      w = 0;
      while (!ps2_clk_oe && w < 2000) begin
         tick();
         w++;
      end
      while (!(busy && !ps2_clk_oe && ps2_data_oe) && w < 2000) begin
         tick();
         w++;
      end
      if (w >= 2000) return;
      ok = 1'b1;
      repeat (20) tick();
      frame[0] = data_line;
      for (int k = 1; k <= n_edges; k++) begin
         dev_clk   = 1'b0;
         last_fall = cyc;
         repeat (20) tick();
         dev_clk = 1'b1;
         repeat (10) tick();
         if (k <= 10) frame[k] = data_line;
         if (k == 10 && ack) dev_data = 1'b0;
         repeat (10) tick();
      end
      dev_data = 1'b1;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int d0, e0, b0, i0, n_att, w, lf;
      logic [10:0] fr;
      bit ok;
      d0 = done_cnt; e0 = err_cnt; b0 = both_cnt; i0 = inh_runs;
      pulse(v.data);
      n_att = v.exp_err ? ATTEMPTS : 1;
      for (int a = 0; a < n_att; a++) begin
         device(v.n_edges, v.ack, fr, lf, ok);
         check({tag, "_dev_start"}, int'(ok), 1);
      end
      w = 0;
      while (busy && w < 1000) begin
         tick();
         w++;
      end
      check({tag, "_busy_release"}, int'(busy), 0);
      repeat (5) tick();
      check({tag, "_done_cnt"}, done_cnt - d0, int'(v.exp_done));
      check({tag, "_err_cnt"}, err_cnt - e0, int'(v.exp_err));
      check({tag, "_done_and_err"}, both_cnt - b0, 0);
      check({tag, "_inhibit_runs"}, inh_runs - i0, n_att);
      check({tag, "_inhibit_len"}, last_run, INH);
      check({tag, "_start_bit_pos"}, last_dpos, INH);
      check({tag, "_busy_at_end"}, int'(end_busy), 0);
      check({tag, "_oe_at_end"}, int'(end_oe), 0);
      if (v.n_edges == 11) begin
         check({tag, "_start_bit"}, int'(fr[0]), 0);
         check({tag, "_byte"}, int'(fr[8:1]), int'(v.exp_byte));
         check({tag, "_parity"}, int'(fr[9]), int'(v.exp_par));
         check({tag, "_stop_bit"}, int'(fr[10]), 1);
      end
      if (v.exp_gap != 0) check({tag, "_timeout_gap"}, err_cyc - lf, v.exp_gap);
   endtask

   initial begin
      #900000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

   vec_t vecs[5];
   vec_t v_echo;
   logic [10:0] fr_b;
   int lf_b, w_b, d0, e0, i0;
   bit ok_b;

   initial begin
      vecs[0] = '{8'hED, 11, 1'b1, 1'b1, 1'b0, 8'hED, 1'b1, 0};
      vecs[1] = '{8'h00, 11, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 0};
      vecs[2] = '{8'hFF, 11, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 0};
      vecs[3] = '{8'hFE, 11, 1'b0, 1'b0, 1'b1, 8'hFE, 1'b0, 0};
      vecs[4] = '{8'hA5, 4,  1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, TMO + EDGE_LAT};
      v_echo  = '{8'hEE, 11, 1'b1, 1'b1, 1'b0, 8'hEE, 1'b1, 0};

      rst      = 1'b0;
      tx_start = 1'b0;
      tx_data  = 8'h00;
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      repeat (3) tick();
      check("reset_clk_oe", int'(ps2_clk_oe), 0);
      check("reset_data_oe", int'(ps2_data_oe), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_err", int'(err), 0);
      rst = 1'b1;
      repeat (5) tick();

      for (int i = 0; i < 5; i++) begin
         run_vec(vecs[i], $sformatf("v%0d", i));
         repeat (20) tick();
      end

      // Reset in the middle of the data bits
      d0 = done_cnt; e0 = err_cnt;
      pulse(8'hED);
      device(2, 1'b0, fr_b, lf_b, ok_b);
      check("midrst_dev_start", int'(ok_b), 1);
      check("midrst_pre_data_oe", int'(ps2_data_oe), 1);
      check("midrst_pre_busy", int'(busy), 1);
      #2;
      rst = 1'b0;
      #1;
      check("midrst_clk_oe", int'(ps2_clk_oe), 0);
      check("midrst_data_oe", int'(ps2_data_oe), 0);
      check("midrst_busy", int'(busy), 0);
      repeat (3) tick();
      rst = 1'b1;
      repeat (50) tick();
      check("midrst_no_done", done_cnt - d0, 0);
      check("midrst_no_err", err_cnt - e0, 0);
      run_vec(v_echo, "after_rst");
      repeat (20) tick();

      // Re-pulse while busy, then again on the done cycle: both must be dropped
      d0 = done_cnt; e0 = err_cnt; i0 = inh_runs;
      pulse(8'h5A);
      fork
         device(11, 1'b1, fr_b, lf_b, ok_b);
         begin
            repeat (150) tick();
            pulse(8'h3C);
            w_b = 0;
            while (!done && w_b < 1500) begin
               tick();
               w_b++;
            end
            check("coinc_done_seen", int'(done), 1);
            tx_data  = 8'h3C;
            tx_start = 1'b1;
            tick();
            tx_start = 1'b0;
         end
      join
      repeat (200) tick();
      check("repulse_dev_start", int'(ok_b), 1);
      check("repulse_byte", int'(fr_b[8:1]), 8'h5A);
      check("repulse_parity", int'(fr_b[9]), 1);
      check("repulse_inhibit_runs", inh_runs - i0, 1);
      check("repulse_done_cnt", done_cnt - d0, 1);
      check("repulse_err_cnt", err_cnt - e0, 0);
      check("repulse_idle_busy", int'(busy), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
